// File: rtl/ann_logsig_sched.sv
// rtl/ann_logsig_sched.sv - round-robin scheduler sharing one pipelined sigmoid unit among N_REQ requesters
// Issues one tagged operand per cycle, routes each result to its issuer and signals layer completion.
module ann_logsig_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int LAT    = 4,
  parameter int IDW    = 2
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
  input  logic                    iLayer_start,
  input  logic [15:0]             iLayer_cnt,
  input  logic [N_REQ-1:0]        iReq,
  input  logic [N_REQ*DATA_W-1:0] iReq_data,
  output logic [N_REQ-1:0]        oGrant,
  output logic                    oSig_valid,
  output logic [DATA_W-1:0]       oSig_data,
  input  logic                    iSig_ready,
  input  logic [DATA_W-1:0]       iSig_data,
  output logic [N_REQ-1:0]        oResp_valid,
  output logic [DATA_W-1:0]       oResp_data,
  output logic                    oLayer_done,
  output logic                    oBusy,
  output logic                    oErr
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic [15:0]                   cnt;
  logic [15:0]                   issue_cnt;
  logic [15:0]                   ret_cnt;
  logic [IDW-1:0]                rr_ptr;
  logic [IDW-1:0]                issue_id;
  logic [LAT+1:1]                tag_v;
  logic [LAT+1:1][IDW-1:0]       tag_id;

  logic [N_REQ-1:0]              eligible;
  logic                          win_found;
  logic [IDW-1:0]                win;
  logic [IDW-1:0]                scan_idx;
  logic [IDW-1:0]                rr_next;
  logic                          issue;

  // A requester whose grant is showing this cycle is masked so it cannot win twice in a row.
  always_comb begin
    eligible  = iReq & ~oGrant;
    win_found = 1'b0;
    win       = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
    rr_next = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    issue   = (state == RUN) && (issue_cnt < cnt) && win_found;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      rr_ptr      <= '0;
      issue_id    <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      oGrant      <= '0;
      oSig_valid  <= 1'b0;
      oSig_data   <= '0;
      oResp_valid <= '0;
      oResp_data  <= '0;
      oLayer_done <= 1'b0;
      oBusy       <= 1'b0;
      oErr        <= 1'b0;
    end else begin
      oGrant      <= '0;
      oSig_valid  <= issue;
      oResp_valid <= '0;
      oLayer_done <= 1'b0;

      if (issue) begin
        oGrant[win] <= 1'b1;
        oSig_data   <= iReq_data[int'(win)*DATA_W +: DATA_W];
        issue_id    <= win;
        rr_ptr      <= rr_next;
        issue_cnt   <= issue_cnt + 16'd1;
      end

      // Tag for the operand on the bus this cycle; stage LAT lines up with the unit's ready strobe.
      tag_v  <= {tag_v[LAT:1], oSig_valid};
      tag_id <= {tag_id[LAT:1], issue_id};

      if (tag_v[LAT] != iSig_ready) begin
        oErr <= 1'b1;
      end

      if (tag_v[LAT+1]) begin
        oResp_valid[tag_id[LAT+1]] <= 1'b1;
        oResp_data                 <= iSig_data;
        ret_cnt                    <= ret_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (iLayer_start) begin
            cnt       <= iLayer_cnt;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            oErr      <= 1'b0;
            if (iLayer_cnt == 16'd0) begin
              state       <= DONE;
              oLayer_done <= 1'b1;
            end else begin
              state <= RUN;
              oBusy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (issue_cnt + 16'd1 == cnt)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (ret_cnt == cnt) begin
            state       <= DONE;
            oBusy       <= 1'b0;
            oLayer_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ann_logsig_sched.sv
// tb/tb_ann_logsig_sched.sv - directed and randomized bench for ann_logsig_sched
// A behavioural sigmoid unit and a scoreboard predict grants, results, timing and layer status.
module tb_ann_logsig_sched;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            layer_start;
  logic [15:0]     layer_cnt;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            sig_valid;
  logic [DW-1:0]   sig_data;
  logic            sig_ready;
  logic [DW-1:0]   sig_in_data;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            layer_done;
  logic            busy;
  logic            err;

  ann_logsig_sched #(.N_REQ(N), .DATA_W(DW), .LAT(LAT), .IDW(2)) dut (
    .iClk(clk), .iReset_n(rst_n), .iLayer_start(layer_start), .iLayer_cnt(layer_cnt),
    .iReq(req), .iReq_data(req_data), .oGrant(grant), .oSig_valid(sig_valid),
    .oSig_data(sig_data), .iSig_ready(sig_ready), .iSig_data(sig_in_data),
    .oResp_valid(resp_valid), .oResp_data(resp_data), .oLayer_done(layer_done),
    .oBusy(busy), .oErr(err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] val; int gc; } ent_t;
  typedef struct { int id; logic [31:0] d; } op_t;

  int total = 0;
  int bad = 0;
  int cyc = 64;
  int n_done = 0;
  int mode = 0;
  bit force_rdy = 1'b0;

  logic [N-1:0] m_g;
  logic [N-1:0] drop_pend;
  int  m_rr, m_cnt, m_issued, m_returned, m_done_cyc;
  bit  m_open, m_err;
  ent_t q[$];
  op_t  opq[$];
  int   glog[$];
  int   rlog_id[$];
  logic [31:0] rlog_val[$];
  bit   iss_hist[64];
  logic hv[64];
  logic [31:0] hd[64];

  // Hard-sigmoid stand-in for the unit: Q8.24 in, 0.5 + x/4 clamped to [0,1].
  function automatic logic [31:0] sig_f(input logic [31:0] x);
    longint v;
    v = 64'sh0080_0000 + (longint'($signed(x)) >>> 2);
    if (v < 0) v = 0;
    if (v > 64'sh0100_0000) v = 64'sh0100_0000;
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); opq.delete();
    m_g = '0; drop_pend = '0; m_rr = 0; m_cnt = 0; m_issued = 0; m_returned = 0;
    m_done_cyc = -1; m_open = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 64; i++) begin iss_hist[i] = 1'b0; hv[i] = 1'b0; hd[i] = '0; end
  endtask

  task automatic clear_logs();
    glog.delete(); rlog_id.delete(); rlog_val.delete(); n_done = 0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_grant"}, grant, 0);
    check({p, "_sig_valid"}, sig_valid, 0);
    check({p, "_sig_data"}, sig_data, 0);
    check({p, "_resp_valid"}, resp_valid, 0);
    check({p, "_resp_data"}, resp_data, 0);
    check({p, "_done"}, layer_done, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err"}, err, 0);
  endtask

  task automatic raise(input int k, input logic [31:0] d);
    req[k] = 1'b1;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic tick();
    logic [N-1:0] g, elig, exp_rv;
    int idx;
    bit found, got;
    g = '0;
    if (m_open && m_issued < m_cnt) begin
      elig = req & ~m_g;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && elig[idx]) begin
          found = 1'b1; g[idx] = 1'b1; m_rr = (idx + 1) % N; m_issued++;
        end
      end
    end
    if (sig_ready != iss_hist[(cyc - LAT) % 64]) m_err = 1'b1;
    if (layer_start) begin
      m_err = 1'b0;
      if (layer_cnt == 16'd0) m_done_cyc = cyc + 1;
      else begin m_open = 1'b1; m_cnt = layer_cnt; m_issued = 0; m_returned = 0; end
    end

    @(posedge clk); #1;
    cyc++;
    layer_start = 1'b0;
    m_g = g;
    iss_hist[cyc % 64] = (g != 0);
    hv[cyc % 64] = sig_valid;
    hd[cyc % 64] = sig_data;
    if (cyc == m_done_cyc) m_open = 1'b0;

    check("grant", grant, g);
    check("sig_valid", sig_valid, (g != 0));
    if (g != 0) begin
      for (int k = 0; k < N; k++) if (g[k]) idx = k;
      check("sig_data", sig_data, req_data[idx*DW +: DW]);
      q.push_back('{idx, sig_f(req_data[idx*DW +: DW]), cyc});
      glog.push_back(idx);
    end
    exp_rv = '0;
    if (q.size() > 0 && q[0].gc + LAT + 2 == cyc) exp_rv[q[0].id] = 1'b1;
    check("resp_valid", resp_valid, exp_rv);
    if (exp_rv != 0) begin
      check("resp_data", resp_data, q[0].val);
      rlog_id.push_back(q[0].id);
      rlog_val.push_back(resp_data);
      void'(q.pop_front());
      m_returned++;
      if (m_returned == m_cnt) m_done_cyc = cyc + 1;
    end
    check("layer_done", layer_done, (cyc == m_done_cyc));
    check("busy", busy, m_open);
    check("err", err, m_err);
    if (layer_done) n_done++;

    req = req & ~drop_pend;
    drop_pend = g;
    for (int k = 0; k < N; k++) begin
      if (!req[k]) begin
        got = 1'b0;
        for (int i = 0; i < opq.size(); i++) begin
          if (!got && opq[i].id == k) begin raise(k, opq[i].d); opq.delete(i); got = 1'b1; end
        end
        if (!got && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1))) raise(k, $urandom);
      end
    end
    sig_ready = force_rdy | hv[(cyc - LAT) % 64];
    sig_in_data = sig_f(hd[(cyc - LAT - 1) % 64]);
  endtask

  task automatic start_layer(input int c);
    layer_start = 1'b1;
    layer_cnt = 16'(c);
    tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!m_open && cyc > m_done_cyc) break;
      tick();
    end
    check("layer_timeout", (!m_open && cyc > m_done_cyc), 1);
  endtask

  task automatic apply_reset(input string p);
    #3 rst_n = 1'b0;
    #1 check_zero(p);
    req = '0; layer_start = 1'b0; force_rdy = 1'b0; sig_ready = 1'b0; sig_in_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; layer_start = 1'b0; layer_cnt = '0; req = '0; req_data = '0;
    sig_ready = 1'b0; sig_in_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;
    tick();

    // Single op: requester 2, operand 0.0
    clear_logs(); mode = 0;
    raise(2, 32'h0000_0000);
    start_layer(1);
    wait_done(40);
    check("single_ngrant", glog.size(), 1);
    if (glog.size() == 1) check("single_gid", glog[0], 2);
    check("single_nresp", rlog_val.size(), 1);
    if (rlog_val.size() == 1) check("single_val", rlog_val[0], 32'h0080_0000);
    check("single_ndone", n_done, 1);

    // Round-robin with all requests held
    apply_reset("rst2");
    tick();
    clear_logs(); mode = 2;
    for (int k = 0; k < N; k++) raise(k, $urandom);
    start_layer(8);
    wait_done(80);
    mode = 0; req = '0; drop_pend = '0;
    check("rr_ngrant", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) begin
      check("rr_order", glog[i], i % N);
      if (i > 0) check("rr_no_repeat", (glog[i] != glog[i-1]), 1);
      if (i < rlog_id.size()) check("rr_resp_order", rlog_id[i], glog[i]);
    end
    check("rr_ndone", n_done, 1);
    tick();

    // Back-to-back with saturation on requester 1
    clear_logs();
    raise(1, 32'h0A00_0000);
    opq.push_back('{1, 32'hF600_0000});
    start_layer(2);
    wait_done(60);
    check("sat_nresp", rlog_id.size(), 2);
    if (rlog_id.size() == 2) begin
      check("sat_id0", rlog_id[0], 1);
      check("sat_id1", rlog_id[1], 1);
      check("sat_val0", rlog_val[0], 32'h0100_0000);
      check("sat_val1", rlog_val[1], 32'h0000_0000);
    end
    tick();

    // Zero count
    clear_logs();
    start_layer(0);
    repeat (3) tick();
    check("zero_ngrant", glog.size(), 0);
    check("zero_ndone", n_done, 1);

    // Stray ready strobe while idle
    clear_logs();
    force_rdy = 1'b1; tick(); force_rdy = 1'b0;
    tick(); tick();
    check("err_set", err, 1);
    repeat (3) tick();
    check("err_sticky", err, 1);
    check("err_nresp", rlog_id.size(), 0);
    raise(0, 32'h0100_0000);
    start_layer(1);
    check("err_cleared", err, 0);
    wait_done(40);
    tick();

    // Reset with operations in flight
    clear_logs(); mode = 2;
    for (int k = 0; k < N; k++) raise(k, $urandom);
    start_layer(8);
    for (int i = 0; i < 20 && glog.size() < 3; i++) tick();
    check("mid_inflight", glog.size(), 3);
    mode = 0;
    apply_reset("rst3");
    clear_logs();
    repeat (12) tick();
    check("mid_nresp", rlog_id.size(), 0);

    // Randomized layers
    mode = 1;
    for (int l = 0; l < 6; l++) begin
      clear_logs();
      start_layer($urandom_range(1, 20));
      wait_done(400);
      check("rand_ndone", n_done, 1);
      check("rand_count", rlog_id.size(), glog.size());
      tick();
    end
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ann_logsig_sched.md
Name: ann_logsig_sched

Overview:
- Shares one pipelined logistic-sigmoid unit among N_REQ neuron accumulators in an ANN layer.
- The sigmoid unit has a fixed LAT-cycle valid latency, with data valid one cycle after its ready strobe.
- Arbitrates requests round-robin, issues at most one operand per cycle, and tags each in-flight operation.
- Routes each result back to the requester that issued it, and counts issued/returned operations to signal layer completion.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 32, operand/result width
- LAT, 4, cycles from the unit sampling its input-ready to asserting its output-ready
- IDW, 2, tag width = ceil(log2(N_REQ))

Ports:
- iClk  in  1  clock
- iReset_n  in  1  asynchronous active-low reset
- iLayer_start  in  1  one-cycle pulse that begins a layer
- iLayer_cnt  in  16  number of sigmoid ops in the layer; sampled with iLayer_start
- iReq  in  N_REQ  per-requester request level; held with data until granted
- iReq_data  in  N_REQ*DATA_W  operand of requester k at bits [k*DATA_W +: DATA_W]
- oGrant  out  N_REQ  one-hot, one-cycle acceptance pulse
- oSig_valid  out  1  drives the unit's input-ready
- oSig_data  out  DATA_W  drives the unit's data input
- iSig_ready  in  1  unit's output-ready
- iSig_data  in  DATA_W  unit's data output
- oResp_valid  out  N_REQ  one-hot, one-cycle result strobe
- oResp_data  out  DATA_W  result, valid with oResp_valid
- oLayer_done  out  1  one-cycle pulse when all layer results have returned
- oBusy  out  1  high in RUN/DRAIN
- oErr  out  1  sticky tag/strobe mismatch flag

Behaviour:
- Reset (async, any time): all outputs 0, FSM=IDLE, rr_ptr=0, counters=0, tag pipe cleared. Results of operations in flight at reset are never delivered.
- FSM transitions:
  - IDLE -> RUN on iLayer_start; latches iLayer_cnt and clears issue_cnt, ret_cnt and oErr.
  - IDLE -> DONE if iLayer_cnt==0.
  - RUN -> DRAIN in the cycle issue_cnt reaches cnt.
  - DRAIN -> DONE when ret_cnt reaches cnt.
  - DONE -> IDLE after one cycle; oLayer_done=1 only in DONE.
  - iLayer_start outside IDLE is ignored.
- Arbitration happens only in RUN with issue_cnt<cnt.
  - eligible = iReq & ~oGrant: a requester granted this cycle cannot win again next cycle.
  - Winner is the first eligible index scanning from rr_ptr upward modulo N_REQ; rr_ptr <= winner+1 mod N_REQ.
  - No eligible requester: no issue, rr_ptr unchanged.
- Issue is registered. If a request wins in cycle t, then in cycle t+1:
  - oGrant[w]=1 and oSig_valid=1;
  - oSig_data = operand of w sampled in t;
  - issue_cnt increments.
  - oSig_data holds its last value when oSig_valid=0.
- Tag pipe: a {valid,id} shift register of depth LAT+1 is pushed every cycle with {oSig_valid, w}.
  - For an issue in cycle t+1, the tag is at stage LAT in cycle t+1+LAT and is checked against iSig_ready.
  - Stage LAT+1 (cycle t+2+LAT) captures iSig_data.
  - Next edge: oResp_valid[id]=1 and oResp_data=captured value; ret_cnt increments.
- Latency with LAT=4: request cycle 0, grant/issue 1, iSig_ready 5, data 6, oResp_valid 7. Throughput is one op per cycle sustained.
- Mismatch handling:
  - iSig_ready=1 with no valid tag at stage LAT, or a valid tag at stage LAT with iSig_ready=0, sets oErr.
  - A valid tag is still returned, with whatever iSig_data holds.
  - A stray strobe returns nothing.
- Counters are 16-bit; issue_cnt never exceeds cnt. ret_cnt counts only tagged returns.
- Simultaneous events:
  - The final issue and a return in the same cycle are both counted.
  - DRAIN->DONE may occur in the cycle after the last oResp_valid.
- oBusy=1 in RUN and DRAIN.

Test Plan:
- Single op: start cnt=1, iReq[2]=1 with data 0x00000000 at cycle 0 -> oGrant=4'b0100 in cycle 1, oResp_valid=4'b0100 with 0x00800000 in cycle 7, oLayer_done in cycle 8.
- Round-robin: all four iReq held high, cnt=8 -> grant order 0,1,2,3,0,1,2,3, with the same requester never granted on consecutive cycles. Each oResp_valid order matches the grant order 6 cycles later, and oLayer_done fires once.
- Back-to-back plus saturation: requester 1 operand 0x0A000000 (+10.0) then 0xF6000000 (-10.0) -> results 0x01000000 then 0x00000000, delivered in order to index 1.
- Zero count: iLayer_start with cnt=0 -> no grant, oLayer_done one cycle later, oBusy stays 0.
- Error: force iSig_ready high with no op in flight -> oErr=1, no oResp_valid. oErr stays 1 until the next iLayer_start.
- Reset mid-layer: assert iReset_n=0 asynchronously with 3 ops in flight -> all outputs 0 immediately, no oResp_valid afterwards, and a new layer runs normally.
